// File: rtl/logic_pod_pkg.sv
// State encoding, default timing and small helpers shared by the pod manager blocks.
package logic_pod_pkg;

  typedef enum logic [2:0] {
    ST_ABSENT     = 3'd0,
    ST_DEBOUNCE   = 3'd1,
    ST_POWER_UP   = 3'd2,
    ST_ALIGN      = 3'd3,
    ST_READY      = 3'd4,
    ST_FAULT_WAIT = 3'd5,
    ST_LOCKOUT    = 3'd6
  } pod_state_t;

  localparam int unsigned DEF_NUM_PODS             = 32'd2;
  localparam int unsigned DEF_DEBOUNCE_CYCLES      = 32'd125000;
  localparam int unsigned DEF_SETTLE_CYCLES        = 32'd1250000;
  localparam int unsigned DEF_ALIGN_TIMEOUT_CYCLES = 32'd12500000;
  localparam int unsigned DEF_RETRY_DELAY_CYCLES   = 32'd12500000;
  localparam int unsigned DEF_MAX_RETRIES          = 32'd3;

  function automatic int unsigned max_of4(input int unsigned a, input int unsigned b,
                                          input int unsigned c, input int unsigned d);
    int unsigned ab;
    int unsigned cd;
    ab = (a > b) ? a : b;
    cd = (c > d) ? c : d;
    return (ab > cd) ? ab : cd;
  endfunction

  function automatic logic is_powered(input pod_state_t s);
    return (s == ST_POWER_UP) || (s == ST_ALIGN) || (s == ST_READY);
  endfunction

endpackage

// File: rtl/logic_pod_manager_if.sv
// Connector, clocking and management-side signals of the pod manager.
interface logic_pod_manager_if #(
  parameter int unsigned NUM_PODS = 32'd2
);
  logic [NUM_PODS-1:0]   pod_present_n;
  logic [NUM_PODS-1:0]   pod_power_fault_n;
  logic [NUM_PODS-1:0]   align_done;
  logic                  ram_ready;
  logic [NUM_PODS-1:0]   pod_power_en;
  logic [NUM_PODS-1:0]   pod_ready;
  logic [NUM_PODS-1:0]   pod_lockout;
  logic [NUM_PODS-1:0]   capture_en;
  logic [3*NUM_PODS-1:0] pod_state;
  logic                  status_change;

  modport master (
    output pod_present_n, pod_power_fault_n, align_done, ram_ready,
    input  pod_power_en, pod_ready, pod_lockout, capture_en, pod_state, status_change
  );

  modport slave (
    input  pod_present_n, pod_power_fault_n, align_done, ram_ready,
    output pod_power_en, pod_ready, pod_lockout, capture_en, pod_state, status_change
  );
endinterface

// File: rtl/logic_pod_power_fsm.sv
// One pod's input synchronisers, bring-up sequencer and bounded fault retry.
module logic_pod_power_fsm
  import logic_pod_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES      = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned SETTLE_CYCLES        = DEF_SETTLE_CYCLES,
  parameter int unsigned ALIGN_TIMEOUT_CYCLES = DEF_ALIGN_TIMEOUT_CYCLES,
  parameter int unsigned RETRY_DELAY_CYCLES   = DEF_RETRY_DELAY_CYCLES,
  parameter int unsigned MAX_RETRIES          = DEF_MAX_RETRIES
) (
  input  logic       clk_125mhz,
  input  logic       rst_n,
  input  logic       i_present_n,
  input  logic       i_fault_n,
  input  logic       i_align_done,
  output logic       o_power_en,
  output logic       o_ready,
  output logic       o_lockout,
  output pod_state_t o_state
);

  localparam int unsigned CNT_W = $clog2(max_of4(DEBOUNCE_CYCLES, SETTLE_CYCLES,
                                  ALIGN_TIMEOUT_CYCLES, RETRY_DELAY_CYCLES)) + 32'd1;
  localparam int unsigned RETRY_W = $clog2(MAX_RETRIES + 32'd1);

  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] SET_LAST   = CNT_W'(SETTLE_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] AT_LAST    = CNT_W'(ALIGN_TIMEOUT_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] RD_LAST    = CNT_W'(RETRY_DELAY_CYCLES - 32'd1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

  logic [1:0]         r_present_sync;
  logic [1:0]         r_fault_sync;
  logic [1:0]         r_align_sync;
  logic               w_present;
  logic               w_fault;
  logic               w_align;
  pod_state_t         r_state;
  pod_state_t         w_state_nxt;
  pod_state_t         w_fault_dest;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [RETRY_W-1:0] r_retry;
  logic [RETRY_W-1:0] w_retry_nxt;
  logic [RETRY_W-1:0] w_retry_inc;
  logic               r_power_en;
  logic               r_ready;
  logic               r_lockout;

  // Idle values are "absent" and "no fault" so reset release never looks like an event
  always_ff @(posedge clk_125mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_present_sync <= 2'b11;
      r_fault_sync   <= 2'b11;
      r_align_sync   <= 2'b00;
    end else begin
      r_present_sync <= {r_present_sync[0], i_present_n};
      r_fault_sync   <= {r_fault_sync[0], i_fault_n};
      r_align_sync   <= {r_align_sync[0], i_align_done};
    end
  end

  assign w_present = ~r_present_sync[1];
  assign w_fault   = ~r_fault_sync[1];
  assign w_align   = r_align_sync[1];

  // Next state: removal beats fault, fault beats timeout, timeout beats normal advance
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt + CNT_W'(1'b1);
    w_retry_nxt  = r_retry;
    w_retry_inc  = r_retry + RETRY_W'(1'b1);
    w_fault_dest = (w_retry_inc == RETRY_MAX) ? ST_LOCKOUT : ST_FAULT_WAIT;
    if (!w_present) begin
      w_state_nxt = ST_ABSENT;
      w_cnt_nxt   = '0;
      w_retry_nxt = '0;
    end else begin
      case (r_state)
        ST_ABSENT: begin
          w_state_nxt = ST_DEBOUNCE;
          w_cnt_nxt   = '0;
        end
        ST_DEBOUNCE: begin
          if (r_cnt == DEB_LAST) begin
            w_state_nxt = ST_POWER_UP;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = ST_DEBOUNCE;
          end
        end
        ST_POWER_UP: begin
          if (w_fault) begin
            w_state_nxt = w_fault_dest;
            w_cnt_nxt   = '0;
            w_retry_nxt = w_retry_inc;
          end else if (r_cnt == SET_LAST) begin
            w_state_nxt = ST_ALIGN;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = ST_POWER_UP;
          end
        end
        ST_ALIGN: begin
          if (w_fault || (r_cnt == AT_LAST)) begin
            w_state_nxt = w_fault_dest;
            w_cnt_nxt   = '0;
            w_retry_nxt = w_retry_inc;
          end else if (w_align) begin
            w_state_nxt = ST_READY;
            w_cnt_nxt   = '0;
            w_retry_nxt = '0;
          end else begin
            w_state_nxt = ST_ALIGN;
          end
        end
        ST_READY: begin
          w_cnt_nxt = '0;
          if (w_fault) begin
            w_state_nxt = w_fault_dest;
            w_retry_nxt = w_retry_inc;
          end else if (!w_align) begin
            w_state_nxt = ST_ALIGN;
          end else begin
            w_state_nxt = ST_READY;
          end
        end
        ST_FAULT_WAIT: begin
          if (r_cnt == RD_LAST) begin
            w_state_nxt = ST_POWER_UP;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = ST_FAULT_WAIT;
          end
        end
        ST_LOCKOUT: begin
          w_state_nxt = ST_LOCKOUT;
          w_cnt_nxt   = '0;
        end
        default: begin
          w_state_nxt = ST_ABSENT;
          w_cnt_nxt   = '0;
          w_retry_nxt = '0;
        end
      endcase
    end
  end

  // Outputs are registered from the next state so they align with the state register
  always_ff @(posedge clk_125mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_ABSENT;
      r_cnt      <= '0;
      r_retry    <= '0;
      r_power_en <= 1'b0;
      r_ready    <= 1'b0;
      r_lockout  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_retry    <= w_retry_nxt;
      r_power_en <= is_powered(w_state_nxt);
      r_ready    <= (w_state_nxt == ST_READY);
      r_lockout  <= (w_state_nxt == ST_LOCKOUT);
    end
  end

  assign o_power_en = r_power_en;
  assign o_ready    = r_ready;
  assign o_lockout  = r_lockout;
  assign o_state    = r_state;

endmodule

// File: rtl/logic_pod_manager.sv
// Hotswap manager top: per-pod sequencers, DRAM-ready capture gating, status change pulse.
module logic_pod_manager
  import logic_pod_pkg::*;
#(
  parameter int unsigned NUM_PODS             = DEF_NUM_PODS,
  parameter int unsigned DEBOUNCE_CYCLES      = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned SETTLE_CYCLES        = DEF_SETTLE_CYCLES,
  parameter int unsigned ALIGN_TIMEOUT_CYCLES = DEF_ALIGN_TIMEOUT_CYCLES,
  parameter int unsigned RETRY_DELAY_CYCLES   = DEF_RETRY_DELAY_CYCLES,
  parameter int unsigned MAX_RETRIES          = DEF_MAX_RETRIES
) (
  input logic          clk_125mhz,
  input logic          rst_n,
  logic_pod_manager_if.slave bus
);

  logic [NUM_PODS-1:0]   w_power_en;
  logic [NUM_PODS-1:0]   w_ready;
  logic [NUM_PODS-1:0]   w_lockout;
  logic [3*NUM_PODS-1:0] w_state_vec;
  logic [3*NUM_PODS-1:0] r_prev_state;
  logic [1:0]            r_ram_sync;
  logic                  r_status_change;

  genvar g;
  generate
    for (g = 0; g < NUM_PODS; g++) begin : g_pod
      pod_state_t w_state;

      logic_pod_power_fsm #(
        .DEBOUNCE_CYCLES      (DEBOUNCE_CYCLES),
        .SETTLE_CYCLES        (SETTLE_CYCLES),
        .ALIGN_TIMEOUT_CYCLES (ALIGN_TIMEOUT_CYCLES),
        .RETRY_DELAY_CYCLES   (RETRY_DELAY_CYCLES),
        .MAX_RETRIES          (MAX_RETRIES)
      ) u_fsm (
        .clk_125mhz   (clk_125mhz),
        .rst_n        (rst_n),
        .i_present_n  (bus.pod_present_n[g]),
        .i_fault_n    (bus.pod_power_fault_n[g]),
        .i_align_done (bus.align_done[g]),
        .o_power_en   (w_power_en[g]),
        .o_ready      (w_ready[g]),
        .o_lockout    (w_lockout[g]),
        .o_state      (w_state)
      );

      assign w_state_vec[3*g +: 3] = w_state;
    end
  endgenerate

  // DRAM-ready synchroniser and one pulse per cycle in which any pod's state moved
  always_ff @(posedge clk_125mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_ram_sync      <= 2'b00;
      r_prev_state    <= '0;
      r_status_change <= 1'b0;
    end else begin
      r_ram_sync      <= {r_ram_sync[0], bus.ram_ready};
      r_prev_state    <= w_state_vec;
      r_status_change <= (w_state_vec != r_prev_state);
    end
  end

  assign bus.pod_power_en  = w_power_en;
  assign bus.pod_ready     = w_ready;
  assign bus.pod_lockout   = w_lockout;
  assign bus.capture_en    = w_ready & {NUM_PODS{r_ram_sync[1]}};
  assign bus.pod_state     = w_state_vec;
  assign bus.status_change = r_status_change;

endmodule

// File: tb/tb_logic_pod_manager.sv
// Directed bench for logic_pod_manager with short timing parameters.
module tb_logic_pod_manager;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  logic [2:0] st0;
  logic [2:0] st1;

  logic_pod_manager_if #(.NUM_PODS(2)) bus ();

  logic_pod_manager #(
    .NUM_PODS(2), .DEBOUNCE_CYCLES(4), .SETTLE_CYCLES(8),
    .ALIGN_TIMEOUT_CYCLES(16), .RETRY_DELAY_CYCLES(8), .MAX_RETRIES(2)
  ) dut (
    .clk_125mhz (clk),
    .rst_n      (rst_n),
    .bus        (bus)
  );

  assign st0 = bus.pod_state[2:0];
  assign st1 = bus.pod_state[5:3];

  initial clk = 1'b0;
  always #4 clk = ~clk;

  // Inputs driven at the returned point count as driven in that cycle; their effect lands 3 edges later.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.pod_present_n = 2'b11; bus.pod_power_fault_n = 2'b11;
    bus.align_done = 2'b00; bus.ram_ready = 1'b0;
    tick(3);
    n_cmp++; if (bus.pod_power_en !== 2'b00) begin n_err++; $display("FAIL rst_power_en: got %b want %b", bus.pod_power_en, 2'b00); end
    n_cmp++; if (bus.pod_state !== 6'd0) begin n_err++; $display("FAIL rst_state: got %h want %h", bus.pod_state, 6'd0); end
    n_cmp++; if ({bus.pod_ready, bus.pod_lockout, bus.capture_en, bus.status_change} !== 7'd0) begin n_err++; $display("FAIL rst_flags: got %b want %b", {bus.pod_ready, bus.pod_lockout, bus.capture_en, bus.status_change}, 7'd0); end
    rst_n = 1'b1;
    tick(3);
    n_cmp++; if (bus.pod_state !== 6'd0) begin n_err++; $display("FAIL post_rst_state: got %h want %h", bus.pod_state, 6'd0); end
  endtask

  task automatic test_bringup();
    bus.pod_present_n[0] = 1'b0; bus.ram_ready = 1'b1;
    tick(2);
    n_cmp++; if (st0 !== 3'd0) begin n_err++; $display("FAIL bu_latency_early: got %0d want %0d", st0, 3'd0); end
    tick(1);
    n_cmp++; if (st0 !== 3'd1) begin n_err++; $display("FAIL bu_debounce: got %0d want %0d", st0, 3'd1); end
    n_cmp++; if (bus.status_change !== 1'b0) begin n_err++; $display("FAIL bu_sc_lag: got %b want %b", bus.status_change, 1'b0); end
    tick(1);
    n_cmp++; if (bus.status_change !== 1'b1) begin n_err++; $display("FAIL bu_sc_deb: got %b want %b", bus.status_change, 1'b1); end
    tick(1);
    n_cmp++; if (bus.status_change !== 1'b0) begin n_err++; $display("FAIL bu_sc_single: got %b want %b", bus.status_change, 1'b0); end
    tick(1);
    n_cmp++; if ({st0, bus.pod_power_en} !== {3'd1, 2'b00}) begin n_err++; $display("FAIL bu_deb_last: got %0d/%b want 1/00", st0, bus.pod_power_en); end
    tick(1);
    n_cmp++; if ({st0, bus.pod_power_en} !== {3'd2, 2'b01}) begin n_err++; $display("FAIL bu_power_up: got %0d/%b want 2/01", st0, bus.pod_power_en); end
    tick(1);
    n_cmp++; if (bus.status_change !== 1'b1) begin n_err++; $display("FAIL bu_sc_pu: got %b want %b", bus.status_change, 1'b1); end
    tick(6);
    n_cmp++; if (st0 !== 3'd2) begin n_err++; $display("FAIL bu_settle_last: got %0d want %0d", st0, 3'd2); end
    tick(1);
    n_cmp++; if ({st0, bus.pod_power_en} !== {3'd3, 2'b01}) begin n_err++; $display("FAIL bu_align: got %0d/%b want 3/01", st0, bus.pod_power_en); end
    tick(4);
    bus.align_done[0] = 1'b1;
    tick(2);
    n_cmp++; if (st0 !== 3'd3) begin n_err++; $display("FAIL bu_align_sync: got %0d want %0d", st0, 3'd3); end
    tick(1);
    n_cmp++; if (st0 !== 3'd4) begin n_err++; $display("FAIL bu_ready: got %0d want %0d", st0, 3'd4); end
    n_cmp++; if ({bus.pod_ready, bus.capture_en, st1} !== {2'b01, 2'b01, 3'd0}) begin n_err++; $display("FAIL bu_ready_cap: got %b/%b/%0d want 01/01/0", bus.pod_ready, bus.capture_en, st1); end
    tick(1);
    n_cmp++; if (bus.status_change !== 1'b1) begin n_err++; $display("FAIL bu_sc_ready: got %b want %b", bus.status_change, 1'b1); end
  endtask

  task automatic test_fault_retry();
    bus.pod_power_fault_n[0] = 1'b0;
    tick(2);
    n_cmp++; if ({st0, bus.pod_power_en} !== {3'd4, 2'b01}) begin n_err++; $display("FAIL fr_early: got %0d/%b want 4/01", st0, bus.pod_power_en); end
    tick(1);
    n_cmp++; if ({st0, bus.pod_power_en} !== {3'd5, 2'b00}) begin n_err++; $display("FAIL fr_fault_wait: got %0d/%b want 5/00", st0, bus.pod_power_en); end
    tick(7);
    n_cmp++; if (st0 !== 3'd5) begin n_err++; $display("FAIL fr_wait_last: got %0d want %0d", st0, 3'd5); end
    tick(1);
    n_cmp++; if ({st0, bus.pod_power_en} !== {3'd2, 2'b01}) begin n_err++; $display("FAIL fr_repower: got %0d/%b want 2/01", st0, bus.pod_power_en); end
    tick(1);
    n_cmp++; if ({st0, bus.pod_lockout, bus.pod_power_en} !== {3'd6, 2'b01, 2'b00}) begin n_err++; $display("FAIL fr_lockout: got %0d/%b/%b want 6/01/00", st0, bus.pod_lockout, bus.pod_power_en); end
    bus.pod_power_fault_n[0] = 1'b1; bus.align_done[0] = 1'b0;
    tick(5);
    n_cmp++; if (st0 !== 3'd6) begin n_err++; $display("FAIL fr_lockout_hold: got %0d want %0d", st0, 3'd6); end
    bus.pod_present_n[0] = 1'b1;
    tick(3);
    n_cmp++; if ({st0, bus.pod_lockout} !== {3'd0, 2'b00}) begin n_err++; $display("FAIL fr_removed: got %0d/%b want 0/00", st0, bus.pod_lockout); end
  endtask

  task automatic test_bounce();
    bus.pod_present_n[0] = 1'b0;
    tick(3);
    bus.pod_present_n[0] = 1'b1;
    n_cmp++; if (st0 !== 3'd1) begin n_err++; $display("FAIL bn_enter: got %0d want %0d", st0, 3'd1); end
    tick(2);
    bus.pod_present_n[0] = 1'b0;
    n_cmp++; if ({st0, bus.pod_power_en} !== {3'd1, 2'b00}) begin n_err++; $display("FAIL bn_short: got %0d/%b want 1/00", st0, bus.pod_power_en); end
    tick(1);
    n_cmp++; if (st0 !== 3'd0) begin n_err++; $display("FAIL bn_abort: got %0d want %0d", st0, 3'd0); end
    tick(1);
    n_cmp++; if (st0 !== 3'd0) begin n_err++; $display("FAIL bn_gap: got %0d want %0d", st0, 3'd0); end
    tick(1);
    n_cmp++; if (st0 !== 3'd1) begin n_err++; $display("FAIL bn_restart: got %0d want %0d", st0, 3'd1); end
    tick(3);
    n_cmp++; if ({st0, bus.pod_power_en} !== {3'd1, 2'b00}) begin n_err++; $display("FAIL bn_steady_last: got %0d/%b want 1/00", st0, bus.pod_power_en); end
    tick(1);
    n_cmp++; if ({st0, bus.pod_power_en} !== {3'd2, 2'b01}) begin n_err++; $display("FAIL bn_power: got %0d/%b want 2/01", st0, bus.pod_power_en); end
  endtask

  task automatic test_align_timeout();
    tick(8);
    n_cmp++; if (st0 !== 3'd3) begin n_err++; $display("FAIL at_align: got %0d want %0d", st0, 3'd3); end
    tick(15);
    n_cmp++; if (st0 !== 3'd3) begin n_err++; $display("FAIL at_align_last: got %0d want %0d", st0, 3'd3); end
    tick(1);
    n_cmp++; if ({st0, bus.pod_power_en} !== {3'd5, 2'b00}) begin n_err++; $display("FAIL at_timeout: got %0d/%b want 5/00", st0, bus.pod_power_en); end
    tick(8);
    n_cmp++; if (st0 !== 3'd2) begin n_err++; $display("FAIL at_retry_pu: got %0d want %0d", st0, 3'd2); end
    tick(8);
    n_cmp++; if (st0 !== 3'd3) begin n_err++; $display("FAIL at_retry_align: got %0d want %0d", st0, 3'd3); end
    tick(16);
    n_cmp++; if ({st0, bus.pod_lockout} !== {3'd6, 2'b01}) begin n_err++; $display("FAIL at_second_lockout: got %0d/%b want 6/01", st0, bus.pod_lockout); end
  endtask

  task automatic test_removal_priority();
    bus.pod_present_n[0] = 1'b1;
    tick(3);
    bus.pod_present_n[0] = 1'b0;
    tick(7);
    n_cmp++; if (st0 !== 3'd2) begin n_err++; $display("FAIL rp_pu: got %0d want %0d", st0, 3'd2); end
    bus.pod_power_fault_n[0] = 1'b0;
    tick(1);
    bus.pod_power_fault_n[0] = 1'b1;
    tick(2);
    n_cmp++; if (st0 !== 3'd5) begin n_err++; $display("FAIL rp_first_fault: got %0d want %0d", st0, 3'd5); end
    tick(8);
    n_cmp++; if (st0 !== 3'd2) begin n_err++; $display("FAIL rp_repower: got %0d want %0d", st0, 3'd2); end
    bus.pod_power_fault_n[0] = 1'b0; bus.pod_present_n[0] = 1'b1;
    tick(3);
    n_cmp++; if ({st0, bus.pod_power_en, bus.pod_lockout} !== {3'd0, 2'b00, 2'b00}) begin n_err++; $display("FAIL rp_removal_wins: got %0d/%b/%b want 0/00/00", st0, bus.pod_power_en, bus.pod_lockout); end
    bus.pod_power_fault_n[0] = 1'b1; bus.pod_present_n[0] = 1'b0;
    tick(7);
    n_cmp++; if (st0 !== 3'd2) begin n_err++; $display("FAIL rp_reinsert_pu: got %0d want %0d", st0, 3'd2); end
    bus.pod_power_fault_n[0] = 1'b0;
    tick(1);
    bus.pod_power_fault_n[0] = 1'b1;
    tick(2);
    n_cmp++; if (st0 !== 3'd5) begin n_err++; $display("FAIL rp_retry_cleared: got %0d want %0d", st0, 3'd5); end
    tick(8);
    bus.align_done[0] = 1'b1;
    tick(8);
    n_cmp++; if (st0 !== 3'd3) begin n_err++; $display("FAIL rp_align: got %0d want %0d", st0, 3'd3); end
    tick(1);
    n_cmp++; if ({st0, bus.pod_ready} !== {3'd4, 2'b01}) begin n_err++; $display("FAIL rp_ready: got %0d/%b want 4/01", st0, bus.pod_ready); end
  endtask

  task automatic test_independence_reset();
    bus.pod_present_n[1] = 1'b0; bus.pod_power_fault_n[1] = 1'b0;
    tick(17);
    n_cmp++; if ({st1, st0} !== {3'd6, 3'd4}) begin n_err++; $display("FAIL ir_states: got %0d/%0d want 6/4", st1, st0); end
    n_cmp++; if ({bus.pod_ready, bus.pod_lockout, bus.capture_en, bus.pod_power_en} !== 8'b01_10_01_01) begin n_err++; $display("FAIL ir_flags: got %b want %b", {bus.pod_ready, bus.pod_lockout, bus.capture_en, bus.pod_power_en}, 8'b01_10_01_01); end
    bus.ram_ready = 1'b0;
    tick(1);
    n_cmp++; if (bus.capture_en !== 2'b01) begin n_err++; $display("FAIL ir_ram_sync: got %b want %b", bus.capture_en, 2'b01); end
    tick(1);
    n_cmp++; if ({bus.capture_en, bus.pod_ready} !== 4'b00_01) begin n_err++; $display("FAIL ir_ram_gate: got %b want %b", {bus.capture_en, bus.pod_ready}, 4'b00_01); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({bus.pod_power_en, bus.pod_ready, bus.pod_lockout, bus.capture_en, bus.status_change} !== 9'd0) begin n_err++; $display("FAIL ir_async_rst: got %b want %b", {bus.pod_power_en, bus.pod_ready, bus.pod_lockout, bus.capture_en, bus.status_change}, 9'd0); end
    n_cmp++; if (bus.pod_state !== 6'd0) begin n_err++; $display("FAIL ir_rst_state: got %h want %h", bus.pod_state, 6'd0); end
    bus.pod_present_n = 2'b11; bus.pod_power_fault_n = 2'b11; bus.align_done = 2'b00;
    tick(1);
    rst_n = 1'b1;
    tick(3);
  endtask

  task automatic test_simultaneous();
    bus.pod_present_n = 2'b00;
    tick(3);
    n_cmp++; if (bus.pod_state !== 6'b001_001) begin n_err++; $display("FAIL sim_states: got %b want %b", bus.pod_state, 6'b001_001); end
    tick(1);
    n_cmp++; if (bus.status_change !== 1'b1) begin n_err++; $display("FAIL sim_pulse: got %b want %b", bus.status_change, 1'b1); end
    tick(1);
    n_cmp++; if (bus.status_change !== 1'b0) begin n_err++; $display("FAIL sim_single: got %b want %b", bus.status_change, 1'b0); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_bringup();
    test_fault_retry();
    test_bounce();
    test_align_timeout();
    test_removal_priority();
    test_independence_reset();
    test_simultaneous();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/logic_pod_manager.md
# logic_pod_manager

Parametrised hotswap and bring-up manager for NUM_PODS logic-analyzer pods. It replaces the fixed two-pod, free-running power control. For each pod it debounces insertion, sequences 12 V enable, waits for capture clock alignment, and retries after power faults with a bounded retry count. It gates per-pod capture on DRAM readiness and reports aggregated status to the management side. It sits between the pod connector pins and the per-pod clocking/datapath instances.

## Interface
Parameters:
- NUM_PODS, 2: number of pods managed.
- DEBOUNCE_CYCLES, 125000: consecutive present cycles required before power-up (1 ms).
- SETTLE_CYCLES, 1250000: 12 V settle time before the alignment wait (10 ms).
- ALIGN_TIMEOUT_CYCLES, 12500000: maximum time in ALIGN before it is treated as a fault (100 ms).
- RETRY_DELAY_CYCLES, 12500000: power-off time after a fault.
- MAX_RETRIES, 3: number of consecutive faults before LOCKOUT.

Ports:
- clk_125mhz, in, 1: sole clock.
- rst_n, in, 1: asynchronous, active-low reset.
- pod_present_n, in, NUM_PODS: async connector sense, low = present.
- pod_power_fault_n, in, NUM_PODS: async hotswap fault, low = fault.
- align_done, in, NUM_PODS: per-pod clocking alignment status, foreign domain.
- ram_ready, in, 1: DRAM calibrated, foreign domain.
- pod_power_en, out, NUM_PODS: 12 V enable.
- pod_ready, out, NUM_PODS: pod in READY.
- pod_lockout, out, NUM_PODS: pod in LOCKOUT.
- capture_en, out, NUM_PODS: pod_ready AND synchronised ram_ready.
- pod_state, out, 3*NUM_PODS: packed per-pod state code, pod i at bits [3i+2:3i].
- status_change, out, 1: one-cycle pulse when any pod state changes.

## Operation
- All async inputs pass through 2-flop synchronisers. Logic sees only synchronised values.
- Each pod has its own FSM. State codes:
  - ABSENT=0
  - DEBOUNCE=1
  - POWER_UP=2
  - ALIGN=3
  - READY=4
  - FAULT_WAIT=5
  - LOCKOUT=6
- ABSENT -> DEBOUNCE when present is seen. The counter is cleared on entry.
- DEBOUNCE:
  - Any deassertion of present -> ABSENT.
  - Counter reaches DEBOUNCE_CYCLES-1 with present still asserted -> POWER_UP.
- POWER_UP: after SETTLE_CYCLES -> ALIGN.
- ALIGN:
  - align_done seen -> READY; the retry count clears.
  - Counter reaches ALIGN_TIMEOUT_CYCLES-1 -> fault path.
- READY: align_done dropping -> ALIGN. The counter is cleared and this is not a fault.
- Fault path:
  - Triggered by a fault seen in POWER_UP, ALIGN or READY, or by an ALIGN timeout.
  - Retry count increments.
  - If the new count equals MAX_RETRIES -> LOCKOUT; otherwise -> FAULT_WAIT.
- FAULT_WAIT: after RETRY_DELAY_CYCLES -> POWER_UP. The fault input is ignored in this state.
- LOCKOUT: exits only via removal.
- Removal (present deasserted) in any state -> ABSENT, and the retry count clears.
- Priority within a cycle: removal > fault > timeout > normal advance.
- Counter width: $clog2 of the largest cycle parameter, plus 1. Retry count width: $clog2(MAX_RETRIES+1).
- Outputs:
  - pod_power_en is registered and high exactly while the state is POWER_UP, ALIGN or READY.
  - pod_ready and pod_lockout are decoded from the registered state.
  - capture_en is pod_ready AND ram_ready after a 2-flop synchroniser.
  - status_change is registered: it goes high the cycle after any state register changes.

## Timing
- Reset values: all outputs 0, all states ABSENT, counters 0.
- Insertion latency:
  - A pod_present_n low sampled at edge k gives state DEBOUNCE after edge k+3.
  - DEBOUNCE occupies exactly DEBOUNCE_CYCLES cycles.
  - pod_power_en rises on the same edge that state becomes POWER_UP.
- Fault latency: a pod_power_fault_n low sampled at edge k gives pod_power_en low after edge k+3.
- POWER_UP lasts exactly SETTLE_CYCLES cycles. FAULT_WAIT lasts exactly RETRY_DELAY_CYCLES cycles.
- status_change lags the pod_state change by 1 cycle. Simultaneous changes on several pods produce a single pulse.
- When rst_n is asserted mid-operation, pod_power_en drops asynchronously with it.

## Structure
- Package logic_pod_pkg holds:
  - typedef enum logic[2:0] pod_state_t with the codes above;
  - default timing localparams.
- Sub-module logic_pod_power_fsm:
  - contains one pod's synchronisers, counter, retry count and FSM;
  - instantiated NUM_PODS times in a generate loop.
- The top level holds the ram_ready synchroniser, the capture_en gating and the status_change detection.

## Test plan
All scenarios use NUM_PODS=2, DEBOUNCE=4, SETTLE=8, ALIGN_TIMEOUT=16, RETRY_DELAY=8, MAX_RETRIES=2.
- Clean bring-up: pod 0 present, align_done raised 5 cycles into ALIGN, ram_ready=1 -> pod_power_en[0] high, then pod_ready[0]=1 and capture_en=2'b01; pod_state[2:0] steps 1,2,3,4 with one status_change pulse per step.
- Bounce: present pulses low for 3 cycles, high, then low steadily -> DEBOUNCE returns to ABSENT, then restarts; power_en stays 0 until 4 steady cycles.
- Fault retry: fault asserted in READY -> power_en low 3 cycles later, FAULT_WAIT for 8 cycles, then POWER_UP; a second fault -> LOCKOUT with pod_lockout[0]=1 and power_en=0.
- Align timeout: align_done never rises -> ALIGN for 16 cycles, then FAULT_WAIT; retry count goes to 1.
- Removal priority: removal and fault in the same cycle -> ABSENT, retry count 0; reinsertion brings the pod up normally.
- Independence and reset: pod 1 in LOCKOUT while pod 0 is READY -> pod_ready=2'b01; with ram_ready=0 -> capture_en=0; rst_n low mid-READY -> all outputs 0 immediately.
